// File: rtl/spi_msg_ctrl_pkg.sv
// ---------------------------------------------------------------------------
// spi_msg_ctrl_pkg
//   Shared definitions for the SPI message sequencer and the spiregs-style
//   command decoders that sit behind it.
//   Contents:
//     msg_state_t    - sequencer states (IDLE, CMD, DATA, WAIT_SSEL)
//     MAX_DATA_BYTES - data bytes stored per message after the command byte
//     MSG_BITS       - width of the packed data / reply word
//     CMD_*          - command codes shared with the decoders
//     msg_byte()     - picks byte n (0 = most significant) out of a packed word
// ---------------------------------------------------------------------------
package spi_msg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_CMD       = 2'd1,
    ST_DATA      = 2'd2,
    ST_WAIT_SSEL = 2'd3
  } msg_state_t;

  localparam int MAX_DATA_BYTES = 8;
  localparam int MSG_BITS       = 8 * MAX_DATA_BYTES;

  localparam logic [7:0] CMD_NOP         = 8'h00;
  localparam logic [7:0] CMD_READ_STATUS = 8'h10;
  localparam logic [7:0] CMD_WRITE_REG   = 8'h12;
  localparam logic [7:0] CMD_READ_REG    = 8'h13;

  // Byte 0 lives in the top byte of the word, so shifting left by 8*n brings
  // byte n to the top; n >= 8 yields zero, which is the idle reply value.
  function automatic logic [7:0] msg_byte(input logic [MSG_BITS-1:0] word,
                                          input logic [3:0]          n);
    logic [MSG_BITS-1:0] shifted;
    shifted = word << (8 * n);
    if (n < 4'(MAX_DATA_BYTES)) return shifted[MSG_BITS-1 -: 8];
    else return 8'h00;
  endfunction

endpackage

// File: rtl/spi_msg_ctrl_if.sv
// ---------------------------------------------------------------------------
// spi_msg_ctrl_if
//   Bus between the SPI byte shifter / command decoders and the message
//   sequencer.
//   Signals:
//     ssel_n           - SPI select, synchronised, low = active
//     rx_byte/rx_valid - received byte and its 1-cycle strobe
//     tx_byte          - next byte for the shifter to send
//     spi_cmd          - command byte of the current / last message
//     spi_rxdata       - packed data bytes, byte 0 in [63:56]
//     spi_msg_end      - 1-cycle pulse when a message completes
//     src_txdata       - per-decoder reply words, source i at [64*i +: 64]
//     src_txdata_valid - per-decoder reply valid
//   Modports:
//     master - the sequencer
//     slave  - shifter and decoders (or a testbench standing in for them)
// ---------------------------------------------------------------------------
interface spi_msg_ctrl_if #(
  parameter int NUM_SRC = 2
);

  logic                   ssel_n;
  logic [7:0]             rx_byte;
  logic                   rx_valid;
  logic [7:0]             tx_byte;
  logic [7:0]             spi_cmd;
  logic [63:0]            spi_rxdata;
  logic                   spi_msg_end;
  logic [64*NUM_SRC-1:0]  src_txdata;
  logic [NUM_SRC-1:0]     src_txdata_valid;

  modport master (
    input  ssel_n, rx_byte, rx_valid, src_txdata, src_txdata_valid,
    output tx_byte, spi_cmd, spi_rxdata, spi_msg_end
  );

  modport slave (
    output ssel_n, rx_byte, rx_valid, src_txdata, src_txdata_valid,
    input  tx_byte, spi_cmd, spi_rxdata, spi_msg_end
  );

endinterface

// File: rtl/spi_msg_ctrl_tx_select.sv
// ---------------------------------------------------------------------------
// spi_tx_select
//   Combinational priority pick over the decoders' reply words: the lowest
//   index with its valid bit set wins.
//   Ports:
//     src_txdata       in  64*NUM_SRC  reply words, source i at [64*i +: 64]
//     src_txdata_valid in  NUM_SRC     reply valid per source
//     sel_data         out 64          winning word, zero when nothing is valid
//     sel_hit          out 1           some source was valid
// ---------------------------------------------------------------------------
module spi_tx_select
  import spi_msg_ctrl_pkg::*;
#(
  parameter int NUM_SRC = 2
) (
  input  logic [MSG_BITS*NUM_SRC-1:0] src_txdata,
  input  logic [NUM_SRC-1:0]          src_txdata_valid,
  output logic [MSG_BITS-1:0]         sel_data,
  output logic                        sel_hit
);

  // Walk from the highest index down so the lowest valid source is the last
  // one written and therefore takes priority.
  always_comb begin
    sel_data = '0;
    sel_hit  = 1'b0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (src_txdata_valid[i]) begin
        sel_data = src_txdata[MSG_BITS*i +: MSG_BITS];
        sel_hit  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_msg_ctrl.sv
// ---------------------------------------------------------------------------
// spi_msg_ctrl
//   Message sequencer between the SPI slave byte shifter and the command
//   decoders. Each SSEL-low transfer is one message: a command byte followed
//   by up to 8 data bytes. Bytes beyond the 8th are dropped and flagged.
//   The reply word of the highest-priority valid decoder is captured at the
//   command byte and streamed out byte by byte on tx_byte.
//   Parameters:
//     NUM_SRC        - number of reply sources, 1..8
//     TIMEOUT_CYCLES - idle clocks inside a message before abort
//   Build option:
//     SPI_MSG_TIMEOUT_EN - enables the in-message idle timeout; without it
//                          WAIT_SSEL is unreachable and msg_aborted stays 0
//   Ports:
//     clk, reset   - system clock, async active-high reset
//     bus          - spi_msg_ctrl_if master (shifter + decoder signals)
//     msg_active   - high while in CMD or DATA
//     msg_overflow - more than 8 data bytes seen in this message (sticky)
//     msg_aborted  - 1-cycle pulse on timeout abort
// ---------------------------------------------------------------------------
module spi_msg_ctrl
  import spi_msg_ctrl_pkg::*;
#(
  parameter int NUM_SRC        = 2,
  parameter int TIMEOUT_CYCLES = 100000
) (
  input  logic              clk,
  input  logic              reset,
  spi_msg_ctrl_if.master    bus,
  output logic              msg_active,
  output logic              msg_overflow,
  output logic              msg_aborted
);

  msg_state_t           state;
  logic [3:0]           idx;
  logic [MSG_BITS-1:0]  snapshot;
  logic [MSG_BITS-1:0]  sel_data;
  logic                 sel_hit;
  logic [MSG_BITS-1:0]  snap_next;
  logic [7:0]           tx_byte_q;
  logic [7:0]           spi_cmd_q;
  logic [MSG_BITS-1:0]  spi_rxdata_q;
  logic                 spi_msg_end_q;
  logic                 overflow_q;
  logic                 aborted_q;
  logic                 in_msg;
  logic                 timeout_hit;

  spi_tx_select #(
    .NUM_SRC (NUM_SRC)
  ) u_tx_select (
    .src_txdata       (bus.src_txdata),
    .src_txdata_valid (bus.src_txdata_valid),
    .sel_data         (sel_data),
    .sel_hit          (sel_hit)
  );

  assign snap_next = sel_hit ? sel_data : '0;
  assign in_msg    = (state == ST_CMD) || (state == ST_DATA);

`ifdef SPI_MSG_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 17) ?
                         $clog2(TIMEOUT_CYCLES + 1) : 17;

  logic [CNT_W-1:0] idle_cnt;
  logic             ssel_n_d;

  // Idle counter: restarts on the select falling edge and on every byte,
  // counts only while a message is open, and rests at zero otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      idle_cnt <= '0;
      ssel_n_d <= 1'b1;
    end else begin
      ssel_n_d <= bus.ssel_n;
      if (bus.rx_valid || (ssel_n_d && !bus.ssel_n) || !in_msg) begin
        idle_cnt <= '0;
      end else if (!timeout_hit) begin
        idle_cnt <= idle_cnt + 1'b1;
      end
    end
  end

  assign timeout_hit = in_msg && (idle_cnt == CNT_W'(TIMEOUT_CYCLES));
`else
  logic [31:0] unused_timeout_cfg;
  assign unused_timeout_cfg = 32'(TIMEOUT_CYCLES);
  assign timeout_hit        = 1'b0;
`endif

  // Message FSM. All bus outputs are registered here. A normal end (select
  // released) takes priority over a timeout in the same cycle, and a byte
  // arriving together with the select release is stored before the end
  // pulse so the decoders see it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      idx           <= 4'd0;
      snapshot      <= '0;
      tx_byte_q     <= 8'h00;
      spi_cmd_q     <= 8'h00;
      spi_rxdata_q  <= '0;
      spi_msg_end_q <= 1'b0;
      overflow_q    <= 1'b0;
      aborted_q     <= 1'b0;
    end else begin
      spi_msg_end_q <= 1'b0;
      aborted_q     <= 1'b0;
      case (state)
        ST_IDLE: begin
          tx_byte_q <= 8'h00;
          if (!bus.ssel_n) state <= ST_CMD;
        end

        ST_CMD: begin
          if (bus.rx_valid) begin
            spi_cmd_q    <= bus.rx_byte;
            spi_rxdata_q <= '0;
            idx          <= 4'd0;
            overflow_q   <= 1'b0;
            snapshot     <= snap_next;
            tx_byte_q    <= msg_byte(snap_next, 4'd0);
            state        <= ST_DATA;
          end else if (bus.ssel_n) begin
            state <= ST_IDLE;
          end else if (timeout_hit) begin
            aborted_q <= 1'b1;
            state     <= ST_WAIT_SSEL;
          end
        end

        ST_DATA: begin
          if (bus.rx_valid) begin
            if (idx < 4'(MAX_DATA_BYTES)) begin
              for (int k = 0; k < MAX_DATA_BYTES; k++) begin
                if (idx == 4'(k)) spi_rxdata_q[MSG_BITS-1-8*k -: 8] <= bus.rx_byte;
              end
              idx       <= idx + 4'd1;
              tx_byte_q <= msg_byte(snapshot, idx + 4'd1);
            end else begin
              overflow_q <= 1'b1;
            end
          end
          if (bus.ssel_n) begin
            spi_msg_end_q <= 1'b1;
            tx_byte_q     <= 8'h00;
            state         <= ST_IDLE;
          end else if (timeout_hit && !bus.rx_valid) begin
            aborted_q <= 1'b1;
            tx_byte_q <= 8'h00;
            state     <= ST_WAIT_SSEL;
          end
        end

        ST_WAIT_SSEL: begin
          tx_byte_q <= 8'h00;
          if (bus.ssel_n) state <= ST_IDLE;
        end

        default: state <= ST_IDLE;
      endcase
    end
  end

  assign bus.tx_byte     = tx_byte_q;
  assign bus.spi_cmd     = spi_cmd_q;
  assign bus.spi_rxdata  = spi_rxdata_q;
  assign bus.spi_msg_end = spi_msg_end_q;
  assign msg_active      = in_msg;
  assign msg_overflow    = overflow_q;
  assign msg_aborted     = aborted_q;

endmodule

// File: tb/tb_spi_msg_ctrl.sv
// ---------------------------------------------------------------------------
// tb_spi_msg_ctrl
//   Drives directed and random SPI messages into spi_msg_ctrl and checks every
//   output on every falling clock edge against a message-level model. A few
//   literal expectations pin the model at known points.
//   Build option: SPI_MSG_TIMEOUT_EN adds the timeout abort scenario.
// ---------------------------------------------------------------------------
module tb_spi_msg_ctrl;

  localparam int NUM_SRC = 2;

  logic clk = 1'b0;
  logic reset;
  logic msg_active;
  logic msg_overflow;
  logic msg_aborted;

  spi_msg_ctrl_if #(.NUM_SRC(NUM_SRC)) bus ();

  spi_msg_ctrl #(
    .NUM_SRC        (NUM_SRC),
    .TIMEOUT_CYCLES (50)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .bus          (bus),
    .msg_active   (msg_active),
    .msg_overflow (msg_overflow),
    .msg_aborted  (msg_aborted)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Message-level model state
  logic        check_en = 1'b1;
  logic [7:0]  exp_cmd  = 8'h00;
  logic [63:0] exp_rxdata = '0;
  logic [7:0]  exp_tx   = 8'h00;
  logic        exp_end  = 1'b0;
  logic        exp_ovf  = 1'b0;
  logic        exp_active = 1'b0;
  logic        have_cmd = 1'b0;
  int          n_stored = 0;
  logic [63:0] snap     = '0;

  task automatic checkOutput(input string name, input logic [63:0] act,
                             input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  // Reply word the decoders offer right now: first valid source counting up.
  function automatic logic [63:0] pickReply();
    for (int i = 0; i < NUM_SRC; i++)
      if (bus.src_txdata_valid[i]) return bus.src_txdata[64*i +: 64];
    return 64'h0;
  endfunction

  function automatic logic [7:0] replyByte(input logic [63:0] w, input int n);
    if (n >= 8) return 8'h00;
    return 8'((w >> (8 * (7 - n))) & 64'hFF);
  endfunction

  // One clock of stimulus; the strobe is always dropped after the edge.
  task automatic applyStimulus(input logic ssel, input logic valid, input logic [7:0] b);
    bus.ssel_n   = ssel;
    bus.rx_valid = valid;
    bus.rx_byte  = b;
    @(posedge clk);
    #1;
    bus.rx_valid = 1'b0;
    exp_end      = 1'b0;
  endtask

  task automatic modelByte(input logic [7:0] b);
    if (!have_cmd) begin
      have_cmd   = 1'b1;
      exp_cmd    = b;
      exp_rxdata = '0;
      exp_ovf    = 1'b0;
      n_stored   = 0;
      snap       = pickReply();
      exp_tx     = replyByte(snap, 0);
    end else if (n_stored < 8) begin
      exp_rxdata = exp_rxdata | ({56'h0, b} << (8 * (7 - n_stored)));
      n_stored++;
      exp_tx = replyByte(snap, n_stored);
    end else begin
      exp_ovf = 1'b1;
    end
  endtask

  task automatic modelEnd();
    if (have_cmd) exp_end = 1'b1;
    exp_active = 1'b0;
    exp_tx     = 8'h00;
    have_cmd   = 1'b0;
  endtask

  task automatic startMsg();
    applyStimulus(1'b0, 1'b0, 8'h00);
    exp_active = 1'b1;
  endtask

  task automatic sendByte(input logic [7:0] b);
    applyStimulus(1'b0, 1'b1, b);
    modelByte(b);
  endtask

  task automatic endMsg();
    applyStimulus(1'b1, 1'b0, 8'h00);
    modelEnd();
  endtask

  task automatic endWithByte(input logic [7:0] b);
    applyStimulus(1'b1, 1'b1, b);
    modelByte(b);
    modelEnd();
  endtask

  task automatic idle(input int n);
    repeat (n) applyStimulus(bus.ssel_n, 1'b0, 8'h00);
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (check_en) begin
      checkOutput("tx_byte", {56'h0, bus.tx_byte}, {56'h0, exp_tx});
      checkOutput("spi_cmd", {56'h0, bus.spi_cmd}, {56'h0, exp_cmd});
      checkOutput("spi_rxdata", bus.spi_rxdata, exp_rxdata);
      checkOutput("spi_msg_end", {63'h0, bus.spi_msg_end}, {63'h0, exp_end});
      checkOutput("msg_overflow", {63'h0, msg_overflow}, {63'h0, exp_ovf});
      checkOutput("msg_active", {63'h0, msg_active}, {63'h0, exp_active});
      checkOutput("msg_aborted", {63'h0, msg_aborted}, 64'h0);
    end
  end

  initial begin
    reset                = 1'b1;
    bus.ssel_n           = 1'b1;
    bus.rx_valid         = 1'b0;
    bus.rx_byte          = 8'h00;
    bus.src_txdata       = '0;
    bus.src_txdata_valid = '0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    idle(2);

    // Test 1: command 12 + one byte
    startMsg();
    sendByte(8'h12);
    sendByte(8'h41);
    endMsg();
    checkOutput("t1_cmd", {56'h0, bus.spi_cmd}, 64'h12);
    checkOutput("t1_rxdata", bus.spi_rxdata, 64'h4100000000000000);
    checkOutput("t1_msg_end", {63'h0, bus.spi_msg_end}, 64'h1);
    idle(2);

    // Test 2: eight data bytes, then a ninth that overflows
    startMsg();
    sendByte(8'h10);
    for (int i = 1; i <= 8; i++) sendByte(8'(i));
    checkOutput("t2_rxdata8", bus.spi_rxdata, 64'h0102030405060708);
    checkOutput("t2_ovf_before", {63'h0, msg_overflow}, 64'h0);
    sendByte(8'hFF);
    checkOutput("t2_rxdata9", bus.spi_rxdata, 64'h0102030405060708);
    checkOutput("t2_ovf_after", {63'h0, msg_overflow}, 64'h1);
    endMsg();
    idle(2);

    // Test 3: reply stream from the lowest valid source, then none valid
    bus.src_txdata       = {64'hAAAAAAAAAAAAAAAA, 64'h1122334455667788};
    bus.src_txdata_valid = 2'b11;
    startMsg();
    sendByte(8'h20);
    checkOutput("t3_tx0", {56'h0, bus.tx_byte}, 64'h11);
    sendByte(8'h01);
    checkOutput("t3_tx1", {56'h0, bus.tx_byte}, 64'h22);
    sendByte(8'h02);
    checkOutput("t3_tx2", {56'h0, bus.tx_byte}, 64'h33);
    sendByte(8'h03);
    endMsg();
    idle(1);
    bus.src_txdata_valid = 2'b00;
    startMsg();
    sendByte(8'h21);
    checkOutput("t3_none_tx0", {56'h0, bus.tx_byte}, 64'h00);
    sendByte(8'h01);
    checkOutput("t3_none_tx1", {56'h0, bus.tx_byte}, 64'h00);
    endMsg();
    idle(2);

    // Test 4: select without bytes, then a last byte coincident with release
    startMsg();
    idle(1);
    endMsg();
    idle(1);
    checkOutput("t4_cmd_kept", {56'h0, bus.spi_cmd}, 64'h21);
    startMsg();
    sendByte(8'h33);
    sendByte(8'h5A);
    endWithByte(8'hC3);
    checkOutput("t4_coincident", bus.spi_rxdata, 64'h5AC3000000000000);
    checkOutput("t4_end", {63'h0, bus.spi_msg_end}, 64'h1);
    idle(2);

    // Test 5: asynchronous reset in the middle of a message
    startMsg();
    sendByte(8'h44);
    sendByte(8'h99);
    bus.ssel_n = 1'b1;
    reset      = 1'b1;
    #1;
    checkOutput("t5_rst_cmd", {56'h0, bus.spi_cmd}, 64'h0);
    checkOutput("t5_rst_active", {63'h0, msg_active}, 64'h0);
    exp_cmd = 8'h00; exp_rxdata = '0; exp_tx = 8'h00; exp_ovf = 1'b0;
    exp_active = 1'b0; exp_end = 1'b0; have_cmd = 1'b0;
    @(posedge clk);
    #1 reset = 1'b0;
    idle(2);
    startMsg();
    sendByte(8'h13);
    sendByte(8'hBE);
    sendByte(8'hEF);
    endMsg();
    checkOutput("t5_after_cmd", {56'h0, bus.spi_cmd}, 64'h13);
    checkOutput("t5_after_data", bus.spi_rxdata, 64'hBEEF000000000000);
    idle(2);

`ifdef SPI_MSG_TIMEOUT_EN
    // Test 6: stall after the command until the timeout aborts the message
    begin
      logic seen_abort;
      logic seen_end;
      seen_abort = 1'b0;
      seen_end   = 1'b0;
      check_en   = 1'b0;
      startMsg();
      sendByte(8'h55);
      for (int c = 0; c < 80 && !seen_abort; c++) begin
        idle(1);
        if (msg_aborted) seen_abort = 1'b1;
        if (bus.spi_msg_end) seen_end = 1'b1;
      end
      checkOutput("t6_abort_seen", {63'h0, seen_abort}, 64'h1);
      applyStimulus(1'b0, 1'b1, 8'h77);
      idle(1);
      checkOutput("t6_byte_ignored", bus.spi_rxdata, 64'h0);
      checkOutput("t6_cmd_kept", {56'h0, bus.spi_cmd}, 64'h55);
      applyStimulus(1'b1, 1'b0, 8'h00);
      for (int c = 0; c < 3; c++) begin
        idle(1);
        if (bus.spi_msg_end) seen_end = 1'b1;
      end
      checkOutput("t6_no_msg_end", {63'h0, seen_end}, 64'h0);
      exp_active = 1'b0; exp_tx = 8'h00; exp_end = 1'b0; have_cmd = 1'b0;
      check_en   = 1'b1;
      idle(2);
    end
`endif

    // Randomized messages
    for (int m = 0; m < 40; m++) begin
      int nbytes;
      bus.src_txdata_valid = 2'($urandom_range(0, 3));
      bus.src_txdata       = {$urandom, $urandom, $urandom, $urandom};
      startMsg();
      idle($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0) begin
        endMsg();
      end else begin
        sendByte(8'($urandom));
        bus.src_txdata_valid = 2'($urandom_range(0, 3));
        bus.src_txdata       = {$urandom, $urandom, $urandom, $urandom};
        nbytes = $urandom_range(0, 10);
        for (int b = 0; b < nbytes; b++) begin
          if (b == nbytes - 1 && $urandom_range(0, 3) == 0) begin
            endWithByte(8'($urandom));
          end else begin
            sendByte(8'($urandom));
            idle($urandom_range(0, 2));
          end
        end
        if (have_cmd) endMsg();
      end
      idle($urandom_range(1, 3));
    end

    idle(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
